// File: rtl/half_subtractor_pkg.sv
// Shared constants for the half_subtractor block.
//   HS_MAX_WIDTH : largest supported lane count
//   HS_DIFF_RST  : reset value of every diff lane
//   HS_BO_RST    : reset value of every borrow lane (also bo_any)
package half_subtractor_pkg;

  localparam int unsigned HS_MAX_WIDTH = 64;

  localparam logic HS_DIFF_RST = 1'b0;
  localparam logic HS_BO_RST   = 1'b0;

endpackage : half_subtractor_pkg

// File: rtl/half_subtractor_cell.sv
// Single-bit half subtractor, purely combinational: a - b with no borrow-in.
//   a, b : minuend / subtrahend bit
//   diff : difference bit
//   bo   : borrow-out bit
module half_sub_cell (
  input  logic a,
  input  logic b,
  output logic diff,
  output logic bo
);

  assign diff = a ^ b;
  assign bo   = ~a & b;

endmodule : half_sub_cell

// File: rtl/half_subtractor.sv
// Registered, lane-parallel half subtractor. Each lane computes a - b
// independently. Results load on an in_valid edge and hold otherwise.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset, priority over in_valid
//   in_valid  : capture strobe for a/b
//   a, b      : per-lane minuend / subtrahend
//   diff, bo  : registered per-lane difference / borrow-out
//   bo_any    : registered OR of the lane borrows
//   out_valid : one-cycle pulse after each accepted strobe
module half_subtractor
  import half_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic [WIDTH-1:0] bo,
  output logic             bo_any,
  output logic             out_valid
);

  // Elaboration-time range check on the lane count.
  if ((WIDTH < 1) || (WIDTH > HS_MAX_WIDTH)) begin : g_width_check
    $error("half_subtractor: WIDTH out of range 1..HS_MAX_WIDTH");
  end

  logic [WIDTH-1:0] diff_c;
  logic [WIDTH-1:0] bo_c;
  logic             bo_any_c;

  // One independent cell per lane; no borrow chaining.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    half_sub_cell u_cell (
      .a    (a[i]),
      .b    (b[i]),
      .diff (diff_c[i]),
      .bo   (bo_c[i])
    );
  end

  assign bo_any_c = |bo_c;

  // Output and valid registers; data holds when not strobed.
  always_ff @(posedge clk) begin
    if (rst) begin
      diff      <= {WIDTH{HS_DIFF_RST}};
      bo        <= {WIDTH{HS_BO_RST}};
      bo_any    <= HS_BO_RST;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        diff   <= diff_c;
        bo     <= bo_c;
        bo_any <= bo_any_c;
      end
    end
  end

endmodule : half_subtractor

// File: tb/tb_half_subtractor.sv
// Scoreboard bench for half_subtractor at WIDTH = 1, 4 and 8.
module tb_half_subtractor;

  typedef struct packed {
    logic       chk;
    logic       ov;
    logic [7:0] diff;
    logic [7:0] bo;
    logic       bo_any;
  } exp_t;

  logic clk;
  logic rst;

  logic       iv1, iv4, iv8;
  logic [0:0] a1, b1;
  logic [3:0] a4, b4;
  logic [7:0] a8, b8;

  logic [0:0] d1, bo1;
  logic [3:0] d4, bo4;
  logic [7:0] d8, bo8;
  logic       ba1, ba4, ba8;
  logic       ov1, ov4, ov8;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t q1[$];
  exp_t q4[$];
  exp_t q8[$];
  exp_t m1, m4, m8;

  half_subtractor #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .a(a1), .b(b1),
    .diff(d1), .bo(bo1), .bo_any(ba1), .out_valid(ov1)
  );
  half_subtractor #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .a(a4), .b(b4),
    .diff(d4), .bo(bo4), .bo_any(ba4), .out_valid(ov4)
  );
  half_subtractor #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .a(a8), .b(b8),
    .diff(d8), .bo(bo8), .bo_any(ba8), .out_valid(ov8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: lane i computes the integer a_i - b_i; a nonzero result is
  // the difference bit, a negative result means a borrow.
  function automatic exp_t model(input exp_t prev, input logic r, input logic iv,
                                 input logic [7:0] a, input logic [7:0] b,
                                 input int w);
    exp_t e;
    int   d;
    e = prev;
    if (r) begin
      e = '0;
      e.chk = 1'b1;
    end else if (iv) begin
      e.diff = '0;
      e.bo   = '0;
      for (int i = 0; i < w; i++) begin
        d = int'(a[i]) - int'(b[i]);
        e.diff[i] = (d != 0);
        e.bo[i]   = (d < 0);
      end
      e.bo_any = (e.bo != 8'd0);
      e.ov     = 1'b1;
    end else begin
      e.ov = 1'b0;
    end
    return e;
  endfunction

  task automatic compare(input string name, input exp_t e, input exp_t g);
    n_tests++;
    if ((g.ov !== e.ov) || (g.diff !== e.diff) || (g.bo !== e.bo) ||
        (g.bo_any !== e.bo_any)) begin
      n_fail++;
      $display("FAIL %s t=%0t got ov=%b diff=%h bo=%h bo_any=%b expected ov=%b diff=%h bo=%h bo_any=%b",
               name, $time, g.ov, g.diff, g.bo, g.bo_any, e.ov, e.diff, e.bo, e.bo_any);
    end
  endtask

  // Apply one edge with the current inputs and queue what each instance must show after it.
  task automatic tick();
    @(posedge clk);
    m1 = model(m1, rst, iv1, 8'(a1), 8'(b1), 1);
    m4 = model(m4, rst, iv4, 8'(a4), 8'(b4), 4);
    m8 = model(m8, rst, iv8, 8'(a8), 8'(b8), 8);
    q1.push_back(m1);
    q4.push_back(m4);
    q8.push_back(m8);
    #1;
  endtask

  // Monitors: one expectation per edge per instance, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e, g;
    if (q1.size() > 0) begin
      e = q1.pop_front();
      g = '{chk: 1'b1, ov: ov1, diff: 8'(d1), bo: 8'(bo1), bo_any: ba1};
      if (e.chk) compare("w1", e, g);
    end
    if (q4.size() > 0) begin
      e = q4.pop_front();
      g = '{chk: 1'b1, ov: ov4, diff: 8'(d4), bo: 8'(bo4), bo_any: ba4};
      if (e.chk) compare("w4", e, g);
    end
    if (q8.size() > 0) begin
      e = q8.pop_front();
      g = '{chk: 1'b1, ov: ov8, diff: 8'(d8), bo: 8'(bo8), bo_any: ba8};
      if (e.chk) compare("w8", e, g);
    end
  end

  initial begin
    logic [1:0] ab;
    m1 = '0; m4 = '0; m8 = '0;
    rst = 1'b1;
    iv1 = 1'b1; a1 = 1'b1; b1 = 1'b0;
    iv4 = 1'b1; a4 = 4'hA; b4 = 4'h3;
    iv8 = 1'b0; a8 = 8'h00; b8 = 8'hFF;

    // Reset held two edges with strobes asserted.
    tick();
    tick();
    rst = 1'b0;
    iv4 = 1'b0;

    // WIDTH=1 truth table, back-to-back strobes.
    for (int k = 0; k < 4; k++) begin
      ab  = 2'(k);
      iv1 = 1'b1; a1 = ab[1]; b1 = ab[0];
      tick();
    end

    // WIDTH=1 hold: strobe 0-1 then toggle inputs without a strobe.
    iv1 = 1'b1; a1 = 1'b0; b1 = 1'b1;
    tick();
    iv1 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      a1 = ~a1; b1 = ~b1;
      tick();
    end

    // WIDTH=4 lanes.
    iv4 = 1'b1; a4 = 4'b1010; b4 = 4'b0110;
    tick();
    a4 = 4'b1111; b4 = 4'b0101;
    tick();

    // WIDTH=4 reset priority over a simultaneous strobe, then the same strobe.
    a4 = 4'h0; b4 = 4'hF;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    iv4 = 1'b0;
    tick();

    // WIDTH=8 random traffic, with occasional mid-stream resets.
    for (int k = 0; k < 1000; k++) begin
      iv8 = 1'($urandom_range(0, 1));
      a8  = 8'($urandom);
      b8  = 8'($urandom);
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0;
    iv8 = 1'b0;
    tick();

    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if ((q1.size() + q4.size() + q8.size()) != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending expected 0", q1.size() + q4.size() + q8.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_half_subtractor
